instr_fetch_unit: RTL and testbench

Parametrised instruction-fetch stage with a local instruction memory, a host load port, stall, and branch/jump redirect. It replaces the fixed 32-entry, word-indexed fetch with configurable width, depth, and PC step. It also adds a registered fetch output with a valid flag, so decode sees a clean pipeline register. It sits at the head of the pipeline and feeds the IF/ID boundary.

---
 rtl/instr_fetch_unit.sv | 66 ++++++
 tb/tb_instr_fetch_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: local instruction memory with a host load port,
// a next-fetch PC with stall and branch/jump redirect, and a registered
// fetch output (instr / pc_out / instr_valid) feeding the IF/ID boundary.
module instr_fetch_unit #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned BYTE_ADDR = 0,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       redirect_en,
  input  logic [31:0]                redirect_pc,
  input  logic                       load_mem_en,
  input  logic [$clog2(DEPTH)-1:0]   load_mem_addr,
  input  logic [DATA_W-1:0]          load_mem_data,
  output logic [DATA_W-1:0]          instr,
  output logic [31:0]                pc_out,
  output logic                       instr_valid
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [31:0] STEP = (BYTE_ADDR != 0) ? 32'd4 : 32'd1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [31:0]       pc;
  logic [AW-1:0]     fetch_idx;

  // Memory index from the PC; upper PC bits drop out so fetch wraps modulo DEPTH.
  always_comb begin
    if (BYTE_ADDR != 0) begin
      fetch_idx = pc[AW+1:2];
    end else begin
      fetch_idx = pc[AW-1:0];
    end
  end

  // Host load port; the array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (load_mem_en) begin
      mem[load_mem_addr] <= load_mem_data;
    end
  end

  // PC and fetch register: load > redirect > stall > advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else if (load_mem_en) begin
      instr_valid <= 1'b0;
    end else if (redirect_en) begin
      pc          <= redirect_pc;
      instr_valid <= 1'b0;
    end else if (!stall) begin
      instr       <= mem[fetch_idx];
      pc_out      <= pc;
      instr_valid <= 1'b1;
      pc          <= pc + STEP;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: one word-addressed and one
// byte-addressed instance share stimulus; a behavioural model per instance
// predicts the fetch register and PC after every edge.
module tb_instr_fetch_unit;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned AW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall;
  logic              redirect_en;
  logic [31:0]       redirect_pc;
  logic              load_mem_en;
  logic [AW-1:0]     load_mem_addr;
  logic [DATA_W-1:0] load_mem_data;

  logic [DATA_W-1:0] instr_w, instr_b;
  logic [31:0]       pc_out_w, pc_out_b;
  logic              valid_w, valid_b;

  int errors = 0;
  int checks = 0;

  // Reference state: shared memory image, per-instance PC and fetch register.
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [31:0]       m_pc     [2];
  logic [DATA_W-1:0] m_instr  [2];
  logic [31:0]       m_pc_out [2];
  logic              m_valid  [2];

  always #5 clk = ~clk;

  instr_fetch_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BYTE_ADDR(0), .RESET_PC(32'h0)) dut_w (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .load_mem_en(load_mem_en), .load_mem_addr(load_mem_addr),
    .load_mem_data(load_mem_data), .instr(instr_w), .pc_out(pc_out_w), .instr_valid(valid_w)
  );

  instr_fetch_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BYTE_ADDR(1), .RESET_PC(32'h0)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .load_mem_en(load_mem_en), .load_mem_addr(load_mem_addr),
    .load_mem_data(load_mem_data), .instr(instr_b), .pc_out(pc_out_b), .instr_valid(valid_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i]     = 32'h0;
      m_instr[i]  = '0;
      m_pc_out[i] = '0;
      m_valid[i]  = 1'b0;
    end
  endtask

  // One clock edge of the specified behaviour for the sampled inputs.
  task automatic model_edge();
    if (load_mem_en) m_mem[load_mem_addr] = load_mem_data;
    for (int i = 0; i < 2; i++) begin
      if (load_mem_en) begin
        m_valid[i] = 1'b0;
      end else if (redirect_en) begin
        m_pc[i]    = redirect_pc;
        m_valid[i] = 1'b0;
      end else if (!stall) begin
        m_instr[i]  = m_mem[(i == 0) ? (m_pc[i] % DEPTH) : ((m_pc[i] / 4) % DEPTH)];
        m_pc_out[i] = m_pc[i];
        m_valid[i]  = 1'b1;
        m_pc[i]     = m_pc[i] + ((i == 0) ? 32'd1 : 32'd4);
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".w.instr"}, 64'(instr_w),  64'(m_instr[0]));
    check({tag, ".w.pc_out"}, 64'(pc_out_w), 64'(m_pc_out[0]));
    check({tag, ".w.valid"}, 64'(valid_w),  64'(m_valid[0]));
    check({tag, ".w.pc"},    64'(dut_w.pc), 64'(m_pc[0]));
    check({tag, ".b.instr"}, 64'(instr_b),  64'(m_instr[1]));
    check({tag, ".b.pc_out"}, 64'(pc_out_b), 64'(m_pc_out[1]));
    check({tag, ".b.valid"}, 64'(valid_b),  64'(m_valid[1]));
    check({tag, ".b.pc"},    64'(dut_b.pc), 64'(m_pc[1]));
  endtask

  // Apply current inputs for one edge, update the model, sample 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    stall = 1'b0; redirect_en = 1'b0; load_mem_en = 1'b0;
  endtask

  task automatic do_load(input int unsigned addr, input logic [DATA_W-1:0] data);
    idle();
    load_mem_en = 1'b1; load_mem_addr = AW'(addr); load_mem_data = data;
    step("load");
    load_mem_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; redirect_pc = '0; load_mem_addr = '0; load_mem_data = '0;
    idle();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill the whole memory so no fetch ever reads an unwritten entry.
    for (int i = 0; i < int'(DEPTH); i++)
      do_load(i, (i < 4) ? DATA_W'(32'hA0 + i) : DATA_W'($urandom));

    // Sequence, with a 3-cycle stall while A1 is presented.
    idle();
    step("seq0");
    check("seq0.const", 64'({instr_w, pc_out_w}), {32'hA0, 32'd0});
    step("seq1");
    check("seq1.const", 64'({instr_w, pc_out_w}), {32'hA1, 32'd1});
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step("stall");
      check("stall.hold", 64'({valid_w, instr_w, pc_out_w}), {1'b1, 32'hA1, 32'd1});
    end
    stall = 1'b0;
    step("seq2");
    check("seq2.const", 64'({instr_w, pc_out_w}), {32'hA2, 32'd2});
    step("seq3");
    check("seq3.const", 64'({instr_w, pc_out_w}), {32'hA3, 32'd3});
    check("seq.pc4", 64'(dut_w.pc), 64'd4);

    // Byte mode: redirect to 0x6 fetches index 1.
    do_load(1, 32'hDEADBEEF);
    redirect_en = 1'b1; redirect_pc = 32'h6;
    step("byte.redir");
    redirect_en = 1'b0;
    step("byte.adv");
    check("byte.const", 64'({valid_b, instr_b, pc_out_b}), {1'b1, 32'hDEADBEEF, 32'h6});
    check("byte.pcA", 64'(dut_b.pc), 64'hA);

    // Redirect wins over stall.
    redirect_en = 1'b1; stall = 1'b1; redirect_pc = 32'h10;
    step("rs.redir");
    check("rs.bubble", 64'(valid_w), 64'd0);
    idle();
    step("rs.adv");
    check("rs.const", 64'({instr_w, pc_out_w}), {m_mem[16], 32'h10});

    // Wrap past the last entry.
    redirect_en = 1'b1; redirect_pc = 32'h1F;
    step("wrap.redir");
    idle();
    step("wrap.a");
    check("wrap.a.const", 64'({instr_w, pc_out_w}), {m_mem[31], 32'h1F});
    step("wrap.b");
    check("wrap.b.const", 64'({instr_w, pc_out_w}), {m_mem[0], 32'h20});

    // Randomised controls.
    for (int n = 0; n < 400; n++) begin
      load_mem_en   = ($urandom_range(0, 9) == 0);
      redirect_en   = ($urandom_range(0, 7) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      load_mem_addr = AW'($urandom);
      load_mem_data = DATA_W'($urandom);
      redirect_pc   = $urandom;
      step("rand");
    end

    // Asynchronous reset pulse between edges; memory must survive.
    idle();
    step("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    rst_n = 1'b1;
    step("post_rst0");
    check("post_rst.const", 64'({valid_w, instr_w, pc_out_w}), {1'b1, m_mem[0], 32'h0});
    step("post_rst1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
